// File: rtl/usb_tx_pkg.sv
// ----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB full-speed transmit line stage:
//   - state_t  : line-stage FSM states
//   - line_t   : pad level pair {dplus, dminus} with J / K / SE0 constants
//   - cnt_w()  : counter width helper (clog2, never below 1 bit)
//   - *_W_DEF  : timer / ones-counter widths for the default parameters
// ----------------------------------------------------------------------------
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  // {dplus, dminus}
  typedef logic [1:0] line_t;
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  // Width for a counter indexed by $clog2(n); a zero-width counter is not legal.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int TMR_W_DEF  = cnt_w(8);
  localparam int ONES_W_DEF = cnt_w(6 + 1);

endpackage

// File: rtl/usb_tx_line_encoder_bit_timer.sv
// ----------------------------------------------------------------------------
// usb_bit_timer
// Divides the system clock into USB bit periods. The counter runs
// 0..CLKS_PER_BIT-1 while run is high and is held at 0 otherwise.
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   run      in  count enable (low = hold at 0)
//   bit_tick out high in the last clock of a bit period (wrap edge follows)
// ----------------------------------------------------------------------------
module usb_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);

  localparam int            TW   = cnt_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (!run || r_cnt == TMAX)  r_cnt <= '0;
    else                             r_cnt <= r_cnt + 1'b1;
  end

  assign bit_tick = run && (r_cnt == TMAX);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// ----------------------------------------------------------------------------
// usb_tx_line_encoder
// USB full-speed transmit line stage. Takes packet bytes (SYNC included)
// through a one-byte holding buffer, serialises them LSB first with bit
// stuffing and NRZI, appends SE0/J end-of-packet and drives the pads.
//   clk, rst      system clock, asynchronous active-high reset
//   in_data/last  packet byte and end-of-packet marker
//   in_valid      byte valid; accepted when in_valid && in_ready
//   in_ready      holding buffer empty
//   dplus_out     D+ level            (registered)
//   dminus_out    D- level            (registered)
//   tx_active     pad output enable   (registered)
//   underrun_err  1-cycle pulse: buffer empty at a byte boundary mid-packet
// ----------------------------------------------------------------------------
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_active,
  output logic       underrun_err
);

  localparam int            OW       = cnt_w(STUFF_LIMIT + 1);
  localparam int            EW       = cnt_w(EOP_SE0_BITS + 1);
  localparam logic [OW-1:0] ONES_LIM = OW'(STUFF_LIMIT);
  localparam logic [EW-1:0] EOP_LAST = EW'(EOP_SE0_BITS - 1);

  state_t        r_state, w_state_n;
  logic [7:0]    r_hold, r_shift, w_shift_n;
  logic          r_hold_last, r_hold_full;
  logic          r_last, w_last_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [OW-1:0] r_ones, w_ones_n;
  logic [EW-1:0] r_eop, w_eop_n;
  line_t         r_line, w_line_n;
  logic          r_txa, w_txa_n;
  logic          r_unr, w_unr_n;
  logic          w_tick, w_accept, w_take, w_emit, w_bnd;

  usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (r_state != ST_IDLE),
    .bit_tick (w_tick)
  );

  assign in_ready = !r_hold_full;
  assign w_accept = in_valid && !r_hold_full;

  // Next-state and next-datapath. Decisions are taken only on leaving IDLE
  // or on the timer wrap; the chosen level becomes visible on that edge.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_last_n  = r_last;
    w_bit_n   = r_bit;
    w_ones_n  = r_ones;
    w_eop_n   = r_eop;
    w_line_n  = r_line;
    w_txa_n   = r_txa;
    w_unr_n   = 1'b0;
    w_take    = 1'b0;
    w_emit    = 1'b0;
    w_bnd     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_take   = 1'b1;
          w_txa_n  = 1'b1;
          w_ones_n = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_ones == ONES_LIM) begin
            // Stuff bit: forced transition, no data consumed.
            w_state_n = ST_STUFF;
            w_line_n  = ~r_line;
            w_ones_n  = '0;
          end else if (r_bit != 3'd7) begin
            w_bit_n = r_bit + 1'b1;
            w_emit  = 1'b1;
          end else begin
            w_bnd = 1'b1;
          end
        end
      end
      ST_STUFF: begin
        if (w_tick) begin
          // A stuff after bit 7 still belongs to its byte.
          if (r_bit == 3'd7) begin
            w_bnd = 1'b1;
          end else begin
            w_state_n = ST_DATA;
            w_bit_n   = r_bit + 1'b1;
            w_emit    = 1'b1;
          end
        end
      end
      ST_EOP_SE0: begin
        if (w_tick) begin
          if (r_eop == EOP_LAST) begin
            w_state_n = ST_EOP_J;
            w_line_n  = LINE_J;
          end else begin
            w_eop_n = r_eop + 1'b1;
          end
        end
      end
      ST_EOP_J: begin
        if (w_tick) begin
          w_state_n = ST_IDLE;
          w_line_n  = LINE_J;
          w_txa_n   = 1'b0;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_line_n  = LINE_J;
        w_txa_n   = 1'b0;
      end
    endcase

    // Byte boundary: end of packet, seamless reload, or truncation.
    if (w_bnd) begin
      if (r_last || !r_hold_full) begin
        w_unr_n   = !r_last;
        w_state_n = ST_EOP_SE0;
        w_line_n  = LINE_SE0;
        w_eop_n   = '0;
      end else begin
        w_take = 1'b1;
      end
    end

    if (w_take) begin
      w_state_n = ST_DATA;
      w_shift_n = r_hold;
      w_last_n  = r_hold_last;
      w_bit_n   = 3'd0;
      w_emit    = 1'b1;
    end

    // NRZI: a 0 toggles J<->K, a 1 holds the line and feeds the stuff count.
    if (w_emit) begin
      if (w_shift_n[w_bit_n]) begin
        w_ones_n = w_ones_n + 1'b1;
      end else begin
        w_ones_n = '0;
        w_line_n = ~r_line;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_last      <= 1'b0;
      r_bit       <= '0;
      r_ones      <= '0;
      r_eop       <= '0;
      r_line      <= LINE_J;
      r_txa       <= 1'b0;
      r_unr       <= 1'b0;
    end else begin
      r_hold_full <= (r_hold_full && !w_take) || w_accept;
      if (w_accept) begin
        r_hold      <= in_data;
        r_hold_last <= in_last;
      end
      r_shift <= w_shift_n;
      r_last  <= w_last_n;
      r_bit   <= w_bit_n;
      r_ones  <= w_ones_n;
      r_eop   <= w_eop_n;
      r_line  <= w_line_n;
      r_txa   <= w_txa_n;
      r_unr   <= w_unr_n;
    end
  end

  assign dplus_out    = r_line[1];
  assign dminus_out   = r_line[0];
  assign tx_active    = r_txa;
  assign underrun_err = r_unr;

endmodule

// File: doc/usb_tx_line_encoder.md
# usb_tx_line_encoder

Parametrised USB full-speed transmit line stage: accepts packet bytes (SYNC included) over a valid/ready handshake and serialises them LSB-first. Applies bit stuffing and NRZI encoding, appends EOP, and drives the D+/D− pad outputs with an output-enable. It sits between the TX packet controller and the pads. It replaces the strobe-driven encoder with an internal bit timer, a one-byte holding buffer, configurable stuffing and EOP generation, and underrun detection.

## Interface
- CLKS_PER_BIT, default 8: system clocks per USB bit period (≥2).
- STUFF_LIMIT, default 6: consecutive data ones before a stuff zero is inserted.
- EOP_SE0_BITS, default 2: SE0 bit periods in EOP.
- One clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_data  in  8  packet byte, transmitted LSB first.
- in_last  in  1  byte is final byte of packet.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  holding buffer empty; byte accepted when in_valid && in_ready.
- dplus_out  out  1  D+ level.
- dminus_out  out  1  D− level.
- tx_active  out  1  pad output enable; high from first bit through end of EOP J.
- underrun_err  out  1  one-cycle pulse: holding buffer empty at byte boundary without prior in_last.

## Operation
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- J = (dplus 1, dminus 0). K = (0, 1). SE0 = (0, 0).
- Buffering: one holding register (byte + last). in_ready = !hold_full. At every byte boundary, and on leaving IDLE, the shifter loads from hold and hold empties.
- IDLE: line J, tx_active 0, bit timer held at 0. A byte in hold moves to DATA: shifter loads, ones counter clears.
- DATA: each bit period emits the next shifter bit.
  - Data 0 toggles the line (J↔K) and clears the ones counter.
  - Data 1 holds the line and increments the ones counter.
- When the ones counter reaches STUFF_LIMIT, the next period is STUFF: line toggles, counter clears, no data consumed. STUFF then returns to DATA or proceeds to EOP per the boundary rules below.
- Byte boundary, after bit 7 and any stuff it triggered:
  - Current byte last: go to EOP_SE0.
  - Hold full: load the next byte, no gap.
  - Hold empty: pulse underrun_err and go to EOP_SE0 (packet truncated).
- A stuff triggered by the final bit of the packet is sent before EOP.
- EOP_SE0: SE0 for EOP_SE0_BITS periods. EOP_J: J for 1 period, then IDLE with tx_active 0.
- Bytes accepted during EOP sit in hold and start a new packet from IDLE. There is no inter-packet gap enforcement; that belongs to the caller.

## Timing
- Reset values: dplus_out 1, dminus_out 0, tx_active 0, underrun_err 0, in_ready 1 (hold empty), state IDLE, counters 0.
- Reset mid-packet returns all outputs to reset values immediately, discards hold and shifter, and leaves no EOP.
- Accept in IDLE at edge N loads hold. At edge N+1, the shifter loads, tx_active rises and the first bit level appears. Each level is held exactly CLKS_PER_BIT cycles.
- The bit timer counts 0..CLKS_PER_BIT-1. The line updates, and the state advances, on the edge where the timer wraps.
- A hold load and a shifter load from hold on the same edge are legal: shifter takes the old hold, hold takes the new byte.
- Packet duration in cycles = CLKS_PER_BIT × (8·bytes + stuffs + EOP_SE0_BITS + 1).
- All outputs are registered; there is no combinational in→out path except in_ready.

## Structure
- Package usb_tx_pkg: state enum; J/K/SE0 line constants; clog2 width localparams for the timer and the ones counter.
- Sub-module usb_bit_timer (parameter CLKS_PER_BIT; ports clk, rst, run, bit_tick) provides the bit strobe.
- Width rules: timer $clog2(CLKS_PER_BIT); ones counter $clog2(STUFF_LIMIT+1); EOP counter $clog2(EOP_SE0_BITS+1).

## Test plan
- Reset: rst high mid-idle and mid-packet → dplus 1, dminus 0, tx_active 0, in_ready 1 within the same cycle.
- Single 0x80 with last, CLKS_PER_BIT 8 → line KJKJKJKK, then SE0 16 cycles, J 8 cycles, then tx_active falls; tx_active high for 88 cycles total.
- 0x80 then 0xFF with last → one stuff after bit 4 of 0xFF, yielding 17 data-phase bit periods before EOP; stuff level is the opposite of the preceding bit.
- Back-to-back 0x80, 0xA5, 0x3C with in_valid held high → in_ready low while hold full, no gap between bytes, NRZI decode recovers the exact bit sequence.
- Underrun: 0x80 without last and no further byte → underrun_err pulses once at end of bit 7, then SE0×2, J, IDLE.
- Parameter sweep CLKS_PER_BIT 4, STUFF_LIMIT 3, EOP_SE0_BITS 3 with 0xFF last after SYNC → stuff every 3 ones, 4-cycle bit periods, 3-period SE0.
